// File: rtl/apb_master_ctrl.sv
// APB master sequencer: turns one upstream request into an APB SETUP/ACCESS
// transfer on one of up to 16 slaves and returns a single-cycle response.
// Wait states are bounded by an optional timeout. Addresses whose slave index
// is not populated are answered with an error and no APB activity.
module apb_master_ctrl #(
  parameter int NSLV      = 16,
  parameter int SLV_SHIFT = 12,
  parameter int TIMEOUT   = 255
) (
  input  logic        PCLK,
  input  logic        PRST,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic        REQ_WRITE,
  input  logic [31:0] REQ_ADDR,
  input  logic [31:0] REQ_WDATA,
  output logic        RSP_VALID,
  output logic [31:0] RSP_RDATA,
  output logic        RSP_ERR,
  output logic [15:0] PSEL,
  output logic        PENABLE,
  output logic        PWRITE,
  output logic [31:0] PADDR,
  output logic [31:0] PWDATA,
  input  logic [31:0] PRDATA,
  input  logic [15:0] PREADY,
  input  logic [15:0] PSLVERR
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_UNMAP  = 2'd3
  } state_t;

  localparam logic [4:0] NSLV_L = 5'(NSLV);
  localparam logic [7:0] TMO_L  = 8'(TIMEOUT);

  state_t      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        req_ready_q, req_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;
  logic [15:0] psel_q, psel_d;
  logic        penable_q, penable_d;
  logic        pwrite_q, pwrite_d;
  logic [31:0] paddr_q, paddr_d;
  logic [31:0] pwdata_q, pwdata_d;

  logic [3:0]  req_idx;
  logic        accept;
  logic        req_mapped;
  logic        sel_ready;
  logic        sel_err;
  logic        tmo_hit;

  assign req_idx    = REQ_ADDR[SLV_SHIFT+3:SLV_SHIFT];
  // REQ_READY is only high in IDLE, so accept implies state_q == S_IDLE.
  assign accept     = REQ_VALID & req_ready_q;
  assign req_mapped = ({1'b0, req_idx} < NSLV_L);
  assign sel_ready  = PREADY[idx_q];
  assign sel_err    = PSLVERR[idx_q];
  assign tmo_hit    = (TMO_L != 8'd0) && (cnt_q == TMO_L);

  // State and registered outputs; reset drops any transfer in flight.
  always_ff @(posedge PCLK) begin
    if (PRST) begin
      state_q     <= S_IDLE;
      idx_q       <= 4'd0;
      cnt_q       <= 8'd0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
      psel_q      <= 16'd0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= 32'd0;
      pwdata_q    <= 32'd0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
    end
  end

  // Next-state: unmapped requests skip the bus; ACCESS ends on ready or timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) state_d = req_mapped ? S_SETUP : S_UNMAP;
      end
      S_SETUP:  state_d = S_ACCESS;
      S_ACCESS: begin
        if (sel_ready || tmo_hit) state_d = S_IDLE;
      end
      S_UNMAP:  state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Next values of the registered outputs, derived from the transition taken.
  always_comb begin
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    req_ready_d = (state_d == S_IDLE);
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (req_mapped) begin
            // Address/control are loaded only for real transfers, so an
            // unmapped request leaves the APB bus completely untouched.
            idx_d     = req_idx;
            psel_d    = 16'd1 << req_idx;
            penable_d = 1'b0;
            pwrite_d  = REQ_WRITE;
            paddr_d   = REQ_ADDR;
            pwdata_d  = REQ_WDATA;
          end else begin
            // UNMAP presents its error response during its single cycle.
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = 32'd0;
          end
        end
      end
      S_SETUP: begin
        penable_d = 1'b1;
        cnt_d     = 8'd0;
      end
      S_ACCESS: begin
        if (sel_ready) begin
          psel_d      = 16'd0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = sel_err;
          rsp_rdata_d = pwrite_q ? 32'd0 : PRDATA;
        end else if (tmo_hit) begin
          psel_d      = 16'd0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = 32'd0;
        end else begin
          // Saturate so a disabled timeout never sees the count wrap.
          cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
        end
      end
      default: ;
    endcase
  end

  assign REQ_READY = req_ready_q;
  assign RSP_VALID = rsp_valid_q;
  assign RSP_RDATA = rsp_rdata_q;
  assign RSP_ERR   = rsp_err_q;
  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Bench for apb_master_ctrl: instance A (16 slaves, timeout 4) and
// instance B (8 slaves, timeout disabled) share the APB slave-side inputs.
// Expected responses are queued at issue time and checked by a monitor.
module tb_apb_master_ctrl;

  logic        PCLK = 1'b0;
  logic        PRST;
  logic        valid_a, valid_b;
  logic        req_write;
  logic [31:0] req_addr, req_wdata;
  logic [31:0] prdata;
  logic [15:0] pready, pslverr;

  logic        a_req_ready, a_rsp_valid, a_rsp_err, a_penable, a_pwrite;
  logic [31:0] a_rsp_rdata, a_paddr, a_pwdata;
  logic [15:0] a_psel;
  logic        b_req_ready, b_rsp_valid, b_rsp_err, b_penable, b_pwrite;
  logic [31:0] b_rsp_rdata, b_paddr, b_pwdata;
  logic [15:0] b_psel;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          at;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  always #5 PCLK = ~PCLK;
  always @(posedge PCLK) cyc <= cyc + 1;

  apb_master_ctrl #(.NSLV(16), .SLV_SHIFT(12), .TIMEOUT(4)) dut_a (
    .PCLK(PCLK), .PRST(PRST),
    .REQ_VALID(valid_a), .REQ_READY(a_req_ready), .REQ_WRITE(req_write),
    .REQ_ADDR(req_addr), .REQ_WDATA(req_wdata),
    .RSP_VALID(a_rsp_valid), .RSP_RDATA(a_rsp_rdata), .RSP_ERR(a_rsp_err),
    .PSEL(a_psel), .PENABLE(a_penable), .PWRITE(a_pwrite),
    .PADDR(a_paddr), .PWDATA(a_pwdata),
    .PRDATA(prdata), .PREADY(pready), .PSLVERR(pslverr)
  );

  apb_master_ctrl #(.NSLV(8), .SLV_SHIFT(12), .TIMEOUT(0)) dut_b (
    .PCLK(PCLK), .PRST(PRST),
    .REQ_VALID(valid_b), .REQ_READY(b_req_ready), .REQ_WRITE(req_write),
    .REQ_ADDR(req_addr), .REQ_WDATA(req_wdata),
    .RSP_VALID(b_rsp_valid), .RSP_RDATA(b_rsp_rdata), .RSP_ERR(b_rsp_err),
    .PSEL(b_psel), .PENABLE(b_penable), .PWRITE(b_pwrite),
    .PADDR(b_paddr), .PWDATA(b_pwdata),
    .PRDATA(prdata), .PREADY(pready), .PSLVERR(pslverr)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Response monitor: every RSP_VALID must match the oldest queued expectation.
  always @(negedge PCLK) begin
    if (a_rsp_valid) begin
      if (qa.size() == 0) begin
        chk("a_unexpected_rsp", 64'(a_rsp_valid), 64'd0);
      end else begin
        exp_t e;
        e = qa.pop_front();
        chk("a_rsp_cycle", 64'(cyc), 64'(e.at));
        chk("a_rsp_rdata", 64'(a_rsp_rdata), 64'(e.rdata));
        chk("a_rsp_err", 64'(a_rsp_err), 64'(e.err));
      end
    end
    if (b_rsp_valid) begin
      if (qb.size() == 0) begin
        chk("b_unexpected_rsp", 64'(b_rsp_valid), 64'd0);
      end else begin
        exp_t e;
        e = qb.pop_front();
        chk("b_rsp_cycle", 64'(cyc), 64'(e.at));
        chk("b_rsp_rdata", 64'(b_rsp_rdata), 64'(e.rdata));
        chk("b_rsp_err", 64'(b_rsp_err), 64'(e.err));
      end
    end
  end

  // Called on a negedge; returns on the next negedge (the SETUP/UNMAP cycle).
  task automatic issue(input bit on_b, input bit wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input bit want_rsp,
                       input logic [31:0] exp_rdata, input bit exp_err, input int lat);
    exp_t e;
    e.rdata = exp_rdata;
    e.err   = exp_err;
    e.at    = cyc + lat;
    if (want_rsp) begin
      if (on_b) qb.push_back(e);
      else      qa.push_back(e);
    end
    if (on_b) chk("b_req_ready_before_issue", 64'(b_req_ready), 64'd1);
    else      chk("a_req_ready_before_issue", 64'(a_req_ready), 64'd1);
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    if (on_b) valid_b = 1'b1;
    else      valid_a = 1'b1;
    @(negedge PCLK);
    valid_a = 1'b0;
    valid_b = 1'b0;
  endtask

  initial begin
    PRST      = 1'b1;
    valid_a   = 1'b0;
    valid_b   = 1'b0;
    req_write = 1'b0;
    req_addr  = 32'd0;
    req_wdata = 32'd0;
    prdata    = 32'd0;
    pready    = 16'hFFFF;
    pslverr   = 16'h0000;
    repeat (3) @(negedge PCLK);
    PRST = 1'b0;
    @(negedge PCLK);

    // Reset state
    chk("rst_a_req_ready", 64'(a_req_ready), 64'd1);
    chk("rst_a_psel", 64'(a_psel), 64'd0);
    chk("rst_a_penable", 64'(a_penable), 64'd0);
    chk("rst_a_paddr", 64'(a_paddr), 64'd0);
    chk("rst_a_rsp", 64'({a_rsp_valid, a_rsp_err, a_rsp_rdata}), 64'd0);
    chk("rst_b_req_ready", 64'(b_req_ready), 64'd1);
    chk("rst_b_psel", 64'(b_psel), 64'd0);

    // 1: zero-wait write to slave 3, other slaves flag errors that must be ignored
    pslverr = 16'hFFF7;
    prdata  = 32'hFFFF_FFFF;
    issue(0, 1, 32'h0000_3010, 32'hA5A5_5A5A, 1, 32'h0, 0, 3);
    chk("t1_setup_psel", 64'(a_psel), 64'h0008);
    chk("t1_setup_penable", 64'(a_penable), 64'd0);
    chk("t1_setup_pwrite", 64'(a_pwrite), 64'd1);
    chk("t1_setup_paddr", 64'(a_paddr), 64'h0000_3010);
    chk("t1_setup_pwdata", 64'(a_pwdata), 64'hA5A5_5A5A);
    chk("t1_setup_req_ready", 64'(a_req_ready), 64'd0);
    @(negedge PCLK);
    chk("t1_access_psel", 64'(a_psel), 64'h0008);
    chk("t1_access_penable", 64'(a_penable), 64'd1);
    chk("t1_access_paddr", 64'(a_paddr), 64'h0000_3010);
    chk("t1_access_pwdata", 64'(a_pwdata), 64'hA5A5_5A5A);
    @(negedge PCLK);
    chk("t1_done_psel", 64'(a_psel), 64'd0);
    chk("t1_done_penable", 64'(a_penable), 64'd0);
    chk("t1_done_paddr_held", 64'(a_paddr), 64'h0000_3010);
    pslverr = 16'h0000;

    // 2: read slave 0 with two wait states
    pready = 16'hFFFE;
    prdata = 32'hDEAD_0000;
    issue(0, 0, 32'h0000_0004, 32'h0, 1, 32'h1234_5678, 0, 5);
    @(negedge PCLK);
    chk("t2_wait1_penable", 64'(a_penable), 64'd1);
    @(negedge PCLK);
    chk("t2_wait2_psel", 64'(a_psel), 64'h0001);
    @(negedge PCLK);
    pready = 16'hFFFF;
    prdata = 32'h1234_5678;
    @(negedge PCLK);
    chk("t2_done_penable", 64'(a_penable), 64'd0);
    prdata = 32'h0;

    // 3a: slave 5 reports an error on the completing cycle
    pslverr = 16'h0020;
    prdata  = 32'hCAFE_F00D;
    issue(0, 0, 32'h0000_5000, 32'h0, 1, 32'hCAFE_F00D, 1, 3);
    repeat (2) @(negedge PCLK);
    // 3b: error only during a wait cycle, cleared on the ready cycle
    pready  = 16'hFFDF;
    pslverr = 16'h0020;
    prdata  = 32'h0102_0304;
    issue(0, 0, 32'h0000_5008, 32'h0, 1, 32'h0102_0304, 0, 4);
    @(negedge PCLK);
    @(negedge PCLK);
    pready  = 16'hFFFF;
    pslverr = 16'h0000;
    @(negedge PCLK);

    // 4a: timeout of 4 on slave 2 => five ACCESS cycles then abort
    pready = 16'hFFFB;
    prdata = 32'h5555_AAAA;
    issue(0, 0, 32'h0000_2000, 32'h0, 1, 32'h0, 1, 7);
    for (int i = 0; i < 5; i++) begin
      @(negedge PCLK);
      chk("t4_access_penable", 64'(a_penable), 64'd1);
      chk("t4_access_psel", 64'(a_psel), 64'h0004);
    end
    @(negedge PCLK);
    chk("t4_abort_psel", 64'(a_psel), 64'd0);
    chk("t4_abort_penable", 64'(a_penable), 64'd0);

    // 4b: timeout disabled on instance B, 300 wait cycles without abort
    issue(1, 0, 32'h0000_2000, 32'h0, 1, 32'h0BAD_F00D, 0, 303);
    repeat (300) @(negedge PCLK);
    chk("t4b_still_penable", 64'(b_penable), 64'd1);
    chk("t4b_still_psel", 64'(b_psel), 64'h0004);
    @(negedge PCLK);
    pready = 16'hFFFF;
    prdata = 32'h0BAD_F00D;
    @(negedge PCLK);
    chk("t4b_done_psel", 64'(b_psel), 64'd0);
    prdata = 32'h0;

    // 5: index 9 is unmapped on the 8-slave instance
    issue(1, 1, 32'h0000_9000, 32'h1111_2222, 1, 32'h0, 1, 1);
    chk("t5_unmap_psel", 64'(b_psel), 64'd0);
    chk("t5_unmap_req_ready", 64'(b_req_ready), 64'd0);
    @(negedge PCLK);
    chk("t5_idle_psel", 64'(b_psel), 64'd0);
    chk("t5_idle_req_ready", 64'(b_req_ready), 64'd1);

    // 6: reset during an ACCESS wait drops the transfer
    pready = 16'hFFFD;
    issue(0, 0, 32'h0000_1000, 32'h0, 0, 32'h0, 0, 0);
    @(negedge PCLK);
    chk("t6_wait_penable", 64'(a_penable), 64'd1);
    PRST      = 1'b1;
    valid_a   = 1'b1;
    req_write = 1'b1;
    req_addr  = 32'h0000_0000;
    @(negedge PCLK);
    chk("t6_rst_psel", 64'(a_psel), 64'd0);
    chk("t6_rst_penable", 64'(a_penable), 64'd0);
    chk("t6_rst_req_ready", 64'(a_req_ready), 64'd1);
    chk("t6_rst_rsp_valid", 64'(a_rsp_valid), 64'd0);
    PRST    = 1'b0;
    valid_a = 1'b0;
    pready  = 16'hFFFF;
    @(negedge PCLK);
    chk("t6_no_accept_psel", 64'(a_psel), 64'd0);

    // 6b: three back-to-back zero-wait transfers, one response every 3 cycles
    prdata = 32'h7777_0001;
    issue(0, 0, 32'h0000_4000, 32'h0, 1, 32'h7777_0001, 0, 3);
    repeat (2) @(negedge PCLK);
    issue(0, 1, 32'h0000_6004, 32'h9999_8888, 1, 32'h0, 0, 3);
    chk("t6b_wr_pwdata", 64'(a_pwdata), 64'h9999_8888);
    repeat (2) @(negedge PCLK);
    issue(0, 0, 32'h0000_F00C, 32'h0, 1, 32'h7777_0001, 0, 3);
    chk("t6b_rd_psel", 64'(a_psel), 64'h8000);

    // Drain outstanding responses within a bounded window
    for (int i = 0; i < 20; i++) begin
      if (qa.size() == 0 && qb.size() == 0) break;
      @(negedge PCLK);
    end
    @(negedge PCLK);
    chk("pending_a", 64'(qa.size()), 64'd0);
    chk("pending_b", 64'(qb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
